// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - integer-ALU reservation station with CDB wakeup and lowest-index issue
module reservation_station #(
   parameter int RS_SIZE  = 16,
   parameter int ROB_ID_W = 5,
   parameter int NO_DEP   = 0,
   parameter int OP_W     = 6,
   parameter int DATA_W   = 32
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   // dispatcher insert port
   input  logic                enable_from_dispatcher,
   input  logic [OP_W-1:0]     op_enum_from_dispatcher,
   input  logic [DATA_W-1:0]   V1_from_dispatcher,
   input  logic [DATA_W-1:0]   V2_from_dispatcher,
   input  logic [ROB_ID_W-1:0] Q1_from_dispatcher,
   input  logic [ROB_ID_W-1:0] Q2_from_dispatcher,
   input  logic [DATA_W-1:0]   imm_from_dispatcher,
   input  logic [DATA_W-1:0]   inst_pos_from_dispatcher,
   input  logic [ROB_ID_W-1:0] rob_id_from_dispatcher,
   output logic                is_full_to_dispatcher,
   // common data buses
   input  logic                enable_from_alu,
   input  logic [ROB_ID_W-1:0] rob_id_from_alu,
   input  logic [DATA_W-1:0]   result_from_alu,
   input  logic                enable_from_lsu,
   input  logic [ROB_ID_W-1:0] rob_id_from_lsu,
   input  logic [DATA_W-1:0]   result_from_lsu,
   // flush
   input  logic                rollback_flag_from_rob,
   // issue port
   output logic                enable_to_alu,
   output logic [OP_W-1:0]     op_enum_to_alu,
   output logic [DATA_W-1:0]   V1_to_alu,
   output logic [DATA_W-1:0]   V2_to_alu,
   output logic [DATA_W-1:0]   imm_to_alu,
   output logic [DATA_W-1:0]   inst_pos_to_alu,
   output logic [ROB_ID_W-1:0] rob_id_to_alu
);

   localparam int IDX_W = $clog2(RS_SIZE);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [ROB_ID_W-1:0] NO_TAG = ROB_ID_W'(NO_DEP);

   // entry storage
   logic [RS_SIZE-1:0]  busy;
   logic [OP_W-1:0]     op_q   [RS_SIZE];
   logic [DATA_W-1:0]   v1_q   [RS_SIZE];
   logic [DATA_W-1:0]   v2_q   [RS_SIZE];
   logic [ROB_ID_W-1:0] q1_q   [RS_SIZE];
   logic [ROB_ID_W-1:0] q2_q   [RS_SIZE];
   logic [DATA_W-1:0]   imm_q  [RS_SIZE];
   logic [DATA_W-1:0]   pos_q  [RS_SIZE];
   logic [ROB_ID_W-1:0] rid_q  [RS_SIZE];

   // operand values after this cycle's CDB snoop
   logic [DATA_W-1:0]   nv1    [RS_SIZE];
   logic [DATA_W-1:0]   nv2    [RS_SIZE];
   logic [ROB_ID_W-1:0] nq1    [RS_SIZE];
   logic [ROB_ID_W-1:0] nq2    [RS_SIZE];
   logic [DATA_W-1:0]   ins_v1;
   logic [DATA_W-1:0]   ins_v2;
   logic [ROB_ID_W-1:0] ins_q1;
   logic [ROB_ID_W-1:0] ins_q2;

   // selection results, all from registered state
   logic [RS_SIZE-1:0]  ready;
   logic                any_ready;
   logic                any_free;
   logic [IDX_W-1:0]    issue_idx;
   logic [IDX_W-1:0]    ins_idx;
   logic [CNT_W-1:0]    free_cnt;

   // A pending tag matches a broadcast only when the bus is valid; NO_TAG never matches.
   function automatic logic cdb_hit(input logic [ROB_ID_W-1:0] tag,
                                    input logic                cdb_en,
                                    input logic [ROB_ID_W-1:0] cdb_tag);
      return cdb_en && (tag != NO_TAG) && (tag == cdb_tag);
   endfunction

   // Lowest-index ready entry, lowest-index free entry and free-entry count.
   always_comb begin
      ready     = '0;
      any_ready = 1'b0;
      any_free  = 1'b0;
      issue_idx = '0;
      ins_idx   = '0;
      free_cnt  = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         ready[i] = busy[i] && (q1_q[i] == NO_TAG) && (q2_q[i] == NO_TAG);
         if (ready[i]) begin
            any_ready = 1'b1;
            issue_idx = IDX_W'(i);
         end
         if (!busy[i]) begin
            any_free = 1'b1;
            ins_idx  = IDX_W'(i);
         end
         free_cnt = free_cnt + {{IDX_W{1'b0}}, ~busy[i]};
      end
   end

   // One entry of slack covers the dispatcher's registered enable.
   assign is_full_to_dispatcher = (free_cnt < CNT_W'(2));

   // Snoop both CDBs for stored operands; the ALU bus wins a same-tag tie.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         nv1[i] = v1_q[i];
         nq1[i] = q1_q[i];
         nv2[i] = v2_q[i];
         nq2[i] = q2_q[i];
         if (cdb_hit(q1_q[i], enable_from_alu, rob_id_from_alu)) begin
            nv1[i] = result_from_alu;
            nq1[i] = NO_TAG;
         end else if (cdb_hit(q1_q[i], enable_from_lsu, rob_id_from_lsu)) begin
            nv1[i] = result_from_lsu;
            nq1[i] = NO_TAG;
         end
         if (cdb_hit(q2_q[i], enable_from_alu, rob_id_from_alu)) begin
            nv2[i] = result_from_alu;
            nq2[i] = NO_TAG;
         end else if (cdb_hit(q2_q[i], enable_from_lsu, rob_id_from_lsu)) begin
            nv2[i] = result_from_lsu;
            nq2[i] = NO_TAG;
         end
      end
   end

   // Snoop both CDBs for the incoming operands so a coinciding broadcast is not lost.
   always_comb begin
      ins_v1 = V1_from_dispatcher;
      ins_q1 = Q1_from_dispatcher;
      ins_v2 = V2_from_dispatcher;
      ins_q2 = Q2_from_dispatcher;
      if (cdb_hit(Q1_from_dispatcher, enable_from_alu, rob_id_from_alu)) begin
         ins_v1 = result_from_alu;
         ins_q1 = NO_TAG;
      end else if (cdb_hit(Q1_from_dispatcher, enable_from_lsu, rob_id_from_lsu)) begin
         ins_v1 = result_from_lsu;
         ins_q1 = NO_TAG;
      end
      if (cdb_hit(Q2_from_dispatcher, enable_from_alu, rob_id_from_alu)) begin
         ins_v2 = result_from_alu;
         ins_q2 = NO_TAG;
      end else if (cdb_hit(Q2_from_dispatcher, enable_from_lsu, rob_id_from_lsu)) begin
         ins_v2 = result_from_lsu;
         ins_q2 = NO_TAG;
      end
   end

   // Entry state and issue registers: rollback beats stall beats normal operation.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy            <= '0;
         enable_to_alu   <= 1'b0;
         op_enum_to_alu  <= '0;
         V1_to_alu       <= '0;
         V2_to_alu       <= '0;
         imm_to_alu      <= '0;
         inst_pos_to_alu <= '0;
         rob_id_to_alu   <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]  <= '0;
            v1_q[i]  <= '0;
            v2_q[i]  <= '0;
            q1_q[i]  <= '0;
            q2_q[i]  <= '0;
            imm_q[i] <= '0;
            pos_q[i] <= '0;
            rid_q[i] <= '0;
         end
      end else if (rollback_flag_from_rob) begin
         busy          <= '0;
         enable_to_alu <= 1'b0;
      end else if (!rdy_in) begin
         enable_to_alu <= 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy[i]) begin
               v1_q[i] <= nv1[i];
               q1_q[i] <= nq1[i];
               v2_q[i] <= nv2[i];
               q2_q[i] <= nq2[i];
            end
         end
         // the insert slot was free before the edge, so it never collides with the issued slot
         if (enable_from_dispatcher && any_free) begin
            busy[ins_idx]  <= 1'b1;
            op_q[ins_idx]  <= op_enum_from_dispatcher;
            v1_q[ins_idx]  <= ins_v1;
            q1_q[ins_idx]  <= ins_q1;
            v2_q[ins_idx]  <= ins_v2;
            q2_q[ins_idx]  <= ins_q2;
            imm_q[ins_idx] <= imm_from_dispatcher;
            pos_q[ins_idx] <= inst_pos_from_dispatcher;
            rid_q[ins_idx] <= rob_id_from_dispatcher;
         end
         if (any_ready) begin
            enable_to_alu    <= 1'b1;
            op_enum_to_alu   <= op_q[issue_idx];
            V1_to_alu        <= v1_q[issue_idx];
            V2_to_alu        <= v2_q[issue_idx];
            imm_to_alu       <= imm_q[issue_idx];
            inst_pos_to_alu  <= pos_q[issue_idx];
            rob_id_to_alu    <= rid_q[issue_idx];
            busy[issue_idx]  <= 1'b0;
         end else begin
            enable_to_alu <= 1'b0;
         end
      end
   end

   // The dispatcher must honour is_full_to_dispatcher; an insert with no room is dropped.
   insert_needs_room: assert property (@(posedge clk_in) disable iff (!rst_in)
      (rdy_in && !rollback_flag_from_rob && enable_from_dispatcher) |-> any_free);

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed and random checks of reservation_station against a slot-array model
module tb_reservation_station;

   localparam int RS = 16;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        enable_from_dispatcher;
   logic [5:0]  op_enum_from_dispatcher;
   logic [31:0] V1_from_dispatcher, V2_from_dispatcher;
   logic [4:0]  Q1_from_dispatcher, Q2_from_dispatcher;
   logic [31:0] imm_from_dispatcher, inst_pos_from_dispatcher;
   logic [4:0]  rob_id_from_dispatcher;
   logic        is_full_to_dispatcher;
   logic        enable_from_alu, enable_from_lsu;
   logic [4:0]  rob_id_from_alu, rob_id_from_lsu;
   logic [31:0] result_from_alu, result_from_lsu;
   logic        rollback_flag_from_rob;
   logic        enable_to_alu;
   logic [5:0]  op_enum_to_alu;
   logic [31:0] V1_to_alu, V2_to_alu, imm_to_alu, inst_pos_to_alu;
   logic [4:0]  rob_id_to_alu;

   reservation_station dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .enable_from_dispatcher(enable_from_dispatcher),
      .op_enum_from_dispatcher(op_enum_from_dispatcher),
      .V1_from_dispatcher(V1_from_dispatcher), .V2_from_dispatcher(V2_from_dispatcher),
      .Q1_from_dispatcher(Q1_from_dispatcher), .Q2_from_dispatcher(Q2_from_dispatcher),
      .imm_from_dispatcher(imm_from_dispatcher),
      .inst_pos_from_dispatcher(inst_pos_from_dispatcher),
      .rob_id_from_dispatcher(rob_id_from_dispatcher),
      .is_full_to_dispatcher(is_full_to_dispatcher),
      .enable_from_alu(enable_from_alu), .rob_id_from_alu(rob_id_from_alu),
      .result_from_alu(result_from_alu),
      .enable_from_lsu(enable_from_lsu), .rob_id_from_lsu(rob_id_from_lsu),
      .result_from_lsu(result_from_lsu),
      .rollback_flag_from_rob(rollback_flag_from_rob),
      .enable_to_alu(enable_to_alu), .op_enum_to_alu(op_enum_to_alu),
      .V1_to_alu(V1_to_alu), .V2_to_alu(V2_to_alu), .imm_to_alu(imm_to_alu),
      .inst_pos_to_alu(inst_pos_to_alu), .rob_id_to_alu(rob_id_to_alu)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic        busy;
      logic [5:0]  op;
      logic [31:0] v1, v2, imm, pos;
      logic [4:0]  q1, q2, rid;
   } ent_t;

   ent_t        m [RS];
   logic        exp_en;
   logic [5:0]  exp_op;
   logic [31:0] exp_v1, exp_v2, exp_imm, exp_pos;
   logic [4:0]  exp_rid;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < RS; i++) m[i] = '0;
      exp_en = 1'b0; exp_op = '0; exp_v1 = '0; exp_v2 = '0;
      exp_imm = '0; exp_pos = '0; exp_rid = '0;
   endfunction

   function automatic int model_free();
      int n = 0;
      for (int i = 0; i < RS; i++) if (!m[i].busy) n++;
      return n;
   endfunction

   // operand after seeing the buses driven this cycle: {tag, value}
   function automatic logic [36:0] resolve(input logic [4:0] q, input logic [31:0] v);
      if (q != 5'd0 && enable_from_alu && q == rob_id_from_alu) return {5'd0, result_from_alu};
      if (q != 5'd0 && enable_from_lsu && q == rob_id_from_lsu) return {5'd0, result_from_lsu};
      return {q, v};
   endfunction

   // advance the model across one clock edge using the inputs currently driven
   function automatic void model_step();
      int sel;
      int slot;
      if (rollback_flag_from_rob) begin
         for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
         exp_en = 1'b0;
         return;
      end
      if (!rdy_in) begin
         exp_en = 1'b0;
         return;
      end
      sel = -1;
      slot = -1;
      for (int i = 0; i < RS; i++) begin
         if (sel < 0 && m[i].busy && m[i].q1 == 5'd0 && m[i].q2 == 5'd0) sel = i;
         if (slot < 0 && !m[i].busy) slot = i;
      end
      if (sel >= 0) begin
         exp_en = 1'b1; exp_op = m[sel].op; exp_v1 = m[sel].v1; exp_v2 = m[sel].v2;
         exp_imm = m[sel].imm; exp_pos = m[sel].pos; exp_rid = m[sel].rid;
         m[sel].busy = 1'b0;
      end else begin
         exp_en = 1'b0;
      end
      for (int i = 0; i < RS; i++) begin
         if (m[i].busy) begin
            {m[i].q1, m[i].v1} = resolve(m[i].q1, m[i].v1);
            {m[i].q2, m[i].v2} = resolve(m[i].q2, m[i].v2);
         end
      end
      if (enable_from_dispatcher && slot >= 0) begin
         m[slot].busy = 1'b1;
         m[slot].op   = op_enum_from_dispatcher;
         m[slot].imm  = imm_from_dispatcher;
         m[slot].pos  = inst_pos_from_dispatcher;
         m[slot].rid  = rob_id_from_dispatcher;
         {m[slot].q1, m[slot].v1} = resolve(Q1_from_dispatcher, V1_from_dispatcher);
         {m[slot].q2, m[slot].v2} = resolve(Q2_from_dispatcher, V2_from_dispatcher);
      end
   endfunction

   task automatic clear_inputs();
      rdy_in = 1'b1;
      enable_from_dispatcher = 1'b0;
      op_enum_from_dispatcher = '0;
      V1_from_dispatcher = '0; V2_from_dispatcher = '0;
      Q1_from_dispatcher = '0; Q2_from_dispatcher = '0;
      imm_from_dispatcher = '0; inst_pos_from_dispatcher = '0;
      rob_id_from_dispatcher = '0;
      enable_from_alu = 1'b0; rob_id_from_alu = '0; result_from_alu = '0;
      enable_from_lsu = 1'b0; rob_id_from_lsu = '0; result_from_lsu = '0;
      rollback_flag_from_rob = 1'b0;
   endtask

   task automatic ins(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] rid);
      enable_from_dispatcher = 1'b1;
      op_enum_from_dispatcher = op;
      V1_from_dispatcher = v1; V2_from_dispatcher = v2;
      Q1_from_dispatcher = q1; Q2_from_dispatcher = q2;
      imm_from_dispatcher = {26'd0, op} + 32'h1000;
      inst_pos_from_dispatcher = {27'd0, rid} << 2;
      rob_id_from_dispatcher = rid;
   endtask

   task automatic alu_cdb(input logic [4:0] tag, input logic [31:0] res);
      enable_from_alu = 1'b1; rob_id_from_alu = tag; result_from_alu = res;
   endtask

   task automatic lsu_cdb(input logic [4:0] tag, input logic [31:0] res);
      enable_from_lsu = 1'b1; rob_id_from_lsu = tag; result_from_lsu = res;
   endtask

   // one clock: model, edge, sample 1 time unit later, compare everything, then idle the inputs
   task automatic step();
      model_step();
      @(posedge clk_in);
      #1;
      chk("enable", 32'(enable_to_alu), 32'(exp_en));
      chk("is_full", 32'(is_full_to_dispatcher), 32'(model_free() < 2));
      chk("op", 32'(op_enum_to_alu), 32'(exp_op));
      chk("v1", V1_to_alu, exp_v1);
      chk("v2", V2_to_alu, exp_v2);
      chk("imm", imm_to_alu, exp_imm);
      chk("pos", inst_pos_to_alu, exp_pos);
      chk("rid", 32'(rob_id_to_alu), 32'(exp_rid));
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_in = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_in);
      #5 rst_in = 1'b1;
      #1;
      chk("rst_enable", 32'(enable_to_alu), 32'd0);
      chk("rst_full", 32'(is_full_to_dispatcher), 32'd0);
      chk("rst_v1", V1_to_alu, 32'd0);
      chk("rst_rid", 32'(rob_id_to_alu), 32'd0);

      // ready ADD issues one cycle after it is written
      ins(6'd1, 32'd5, 32'd7, 5'd0, 5'd0, 5'd3);
      step();
      chk("t1_no_early", 32'(enable_to_alu), 32'd0);
      step();
      chk("t1_en", 32'(enable_to_alu), 32'd1);
      chk("t1_v1", V1_to_alu, 32'd5);
      chk("t1_v2", V2_to_alu, 32'd7);
      chk("t1_rid", 32'(rob_id_to_alu), 32'd3);
      step();
      chk("t1_pulse", 32'(enable_to_alu), 32'd0);

      // pending Q1 woken by the ALU bus
      ins(6'd2, 32'd0, 32'd9, 5'd4, 5'd0, 5'd5);
      step();
      step();
      chk("t2_wait", 32'(enable_to_alu), 32'd0);
      alu_cdb(5'd4, 32'h100);
      step();
      chk("t2_wake_edge", 32'(enable_to_alu), 32'd0);
      step();
      chk("t2_en", 32'(enable_to_alu), 32'd1);
      chk("t2_v1", V1_to_alu, 32'h100);
      chk("t2_v2", V2_to_alu, 32'd9);

      // LSU broadcast coinciding with the insert
      ins(6'd3, 32'd1, 32'd0, 5'd0, 5'd6, 5'd8);
      lsu_cdb(5'd6, 32'hAB);
      step();
      step();
      chk("t3_en", 32'(enable_to_alu), 32'd1);
      chk("t3_v2", V2_to_alu, 32'hAB);
      step();

      // fill 15 entries waiting on tag 7, then release them in index order
      for (int i = 0; i < 15; i++) begin
         ins(6'(i), 32'd0, 32'(i), 5'd7, 5'd0, 5'(i + 1));
         step();
      end
      chk("t4_full", 32'(is_full_to_dispatcher), 32'd1);
      alu_cdb(5'd7, 32'hC0DE);
      step();
      chk("t4_wake_edge", 32'(enable_to_alu), 32'd0);
      for (int i = 0; i < 15; i++) begin
         step();
         chk("t4_order_en", 32'(enable_to_alu), 32'd1);
         chk("t4_order_rid", 32'(rob_id_to_alu), 32'(i + 1));
         if (i == 0) chk("t4_full_drop", 32'(is_full_to_dispatcher), 32'd0);
      end
      step();

      // rollback with two ready entries and a coinciding insert
      for (int i = 0; i < 3; i++) begin
         ins(6'd4, 32'd0, 32'd0, 5'd9, 5'd0, 5'(20 + i));
         step();
      end
      for (int i = 0; i < 2; i++) begin
         ins(6'd5, 32'd0, 32'd0, 5'd0, 5'd10, 5'(23 + i));
         step();
      end
      alu_cdb(5'd10, 32'h55);
      step();
      ins(6'd6, 32'd1, 32'd2, 5'd0, 5'd0, 5'd25);
      rollback_flag_from_rob = 1'b1;
      step();
      chk("t5_en", 32'(enable_to_alu), 32'd0);
      chk("t5_full", 32'(is_full_to_dispatcher), 32'd0);
      alu_cdb(5'd9, 32'h99);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_quiet", 32'(enable_to_alu), 32'd0);
      end

      // stall with ready entries, then resume from the lowest index
      for (int i = 0; i < 3; i++) begin
         ins(6'd7, 32'(i), 32'd0, 5'd11, 5'd0, 5'(i + 1));
         step();
      end
      lsu_cdb(5'd11, 32'h77);
      step();
      for (int i = 0; i < 3; i++) begin
         rdy_in = 1'b0;
         step();
         chk("t6_stall", 32'(enable_to_alu), 32'd0);
      end
      step();
      chk("t6_resume_en", 32'(enable_to_alu), 32'd1);
      chk("t6_resume_rid", 32'(rob_id_to_alu), 32'd1);
      step();
      chk("t6_next_rid", 32'(rob_id_to_alu), 32'd2);

      // asynchronous reset mid-cycle
      #1 rst_in = 1'b0;
      #1;
      chk("arst_en", 32'(enable_to_alu), 32'd0);
      chk("arst_v1", V1_to_alu, 32'd0);
      chk("arst_rid", 32'(rob_id_to_alu), 32'd0);
      chk("arst_full", 32'(is_full_to_dispatcher), 32'd0);
      #3 rst_in = 1'b1;
      model_reset();

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         rdy_in = ($urandom % 8) != 0;
         if (rdy_in && ($urandom % 50) == 0) rollback_flag_from_rob = 1'b1;
         if (($urandom % 5) < 3 && model_free() > 0)
            ins(6'($urandom), $urandom, $urandom,
                (($urandom % 3) == 0) ? 5'($urandom_range(1, 6)) : 5'd0,
                (($urandom % 3) == 0) ? 5'($urandom_range(0, 6)) : 5'd0,
                5'($urandom_range(1, 31)));
         if ($urandom % 2) alu_cdb(5'($urandom_range(0, 6)), $urandom);
         if ($urandom % 2) lsu_cdb(5'($urandom_range(0, 6)), $urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Integer-ALU reservation station, directly downstream of the dispatcher in the Tomasulo core.
- Accepts one decoded non-memory instruction per cycle from the dispatcher, with operands already renamed: values V1/V2 and tags Q1/Q2.
- Snoops the ALU and LSU CDB results to wake up pending operands.
- Issues at most one ready instruction per cycle to the ALU. Cleared on ROB rollback.

Parameters:
- RS_SIZE, 16, number of entries; power of two, ≥4.
- ROB_ID_W, 5, tag width.
- NO_DEP, 0, tag value meaning "operand valid, no dependency".
- OP_W, 6, op-enum width.
- DATA_W, 32, data and address width.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global ready; low = stall.
- enable_from_dispatcher  in  1  insert request.
- op_enum_from_dispatcher  in  OP_W  operation.
- V1_from_dispatcher, V2_from_dispatcher  in  DATA_W  operand values.
- Q1_from_dispatcher, Q2_from_dispatcher  in  ROB_ID_W  operand tags.
- imm_from_dispatcher  in  DATA_W  immediate.
- inst_pos_from_dispatcher  in  DATA_W  PC.
- rob_id_from_dispatcher  in  ROB_ID_W  destination tag.
- is_full_to_dispatcher  out  1  no room for further inserts.
- enable_from_alu, enable_from_lsu  in  1  CDB valid.
- rob_id_from_alu, rob_id_from_lsu  in  ROB_ID_W  CDB tags.
- result_from_alu, result_from_lsu  in  DATA_W  CDB data.
- rollback_flag_from_rob  in  1  flush.
- enable_to_alu  out  1  issue valid, one-cycle pulse.
- op_enum_to_alu  out  OP_W  issued op.
- V1_to_alu, V2_to_alu, imm_to_alu, inst_pos_to_alu  out  DATA_W  issued operands.
- rob_id_to_alu  out  ROB_ID_W  issued tag.

Behaviour:
- Reset (rst_in low, asynchronous): all entry busy bits 0, enable_to_alu 0, all other ALU outputs 0. is_full_to_dispatcher is 0 after reset because it is derived from the busy bits.
- Entry state: busy, op, V1, V2, Q1, Q2, imm, inst_pos, rob_id. An entry is ready when busy, Q1==NO_DEP and Q2==NO_DEP.
- is_full_to_dispatcher is combinational from registered state: 1 when free entries < 2. This gives one entry of slack for the dispatcher's registered enable.
- Priority at each edge: rollback > rdy_in low > normal.
- Rollback (rdy_in high, rollback_flag_from_rob high):
  - All busy bits cleared; enable_to_alu <= 0.
  - Any same-cycle insert is discarded.
- rdy_in low: all state held; enable_to_alu <= 0.
- Normal cycle, all performed together from pre-edge state:
  - Wakeup: for every busy entry and each operand, if enable_from_alu and Qx==rob_id_from_alu, set Vx <= result_from_alu and Qx <= NO_DEP. Otherwise apply the same rule for the LSU. An ALU match takes priority if both CDBs carry the same tag.
  - Tags equal to NO_DEP never match.
  - Insert: if enable_from_dispatcher, write into the lowest-index non-busy entry and set busy.
  - Incoming Q1/Q2 are checked against both CDBs in the same cycle, with the same rule as wakeup, so a broadcast coinciding with the insert is not lost.
  - Insert with no free entry is a protocol violation: the instruction is dropped and a simulation-only error is flagged.
  - Issue: select the lowest-index ready entry, judged on pre-edge state.
    - Selected: register its fields onto the *_to_alu outputs, enable_to_alu <= 1, clear its busy bit.
    - None ready: enable_to_alu <= 0. The data outputs hold their last value.
  - An entry freed by issue is not reusable for an insert on the same edge.
  - An entry made ready by wakeup on edge E is issuable at the earliest on edge E+1.
- Latency:
  - An inserted instruction with both operands ready is written at edge E and appears with enable_to_alu=1 after edge E+1.
  - With a pending operand resolved by a CDB broadcast at edge W, it issues after edge W+1 at the earliest.
- Throughput: 1 insert and 1 issue per cycle.

Test Plan:
- Reset, then insert ADD with Q1=Q2=0, V1=5, V2=7, rob_id=3 → one cycle later enable_to_alu=1, V1_to_alu=5, V2_to_alu=7, rob_id_to_alu=3; the following cycle enable_to_alu=0.
- Insert an op with Q1=4, V2=9 ready, then drive ALU CDB tag 4 with result 0x100 → issue one cycle after the broadcast with V1_to_alu=0x100; no issue before the broadcast.
- Insert an op with Q2=6 in the same cycle that the LSU CDB broadcasts tag 6 with data 0xAB → issues next cycle with V2_to_alu=0xAB (same-cycle capture).
- Insert 15 instructions all waiting on tag 7 → is_full_to_dispatcher=1. Broadcast tag 7 → entries issue in index order 0..14, one per cycle, and is_full drops once 2 entries are free.
- Fill 5 entries, two of them ready, and assert rollback together with an insert → no issue that cycle or after, all entries empty, is_full=0, the inserted instruction is absent.
- Hold rdy_in low for 3 cycles with ready entries → no enable_to_alu pulses. After release, issue resumes with the lowest index. Pulse rst_in low mid-operation → outputs are 0 immediately, asynchronously.
